seq_det_ctrl: RTL
=================

Name: seq_det_ctrl

Overview:
Programmable serial pattern-detector controller. It generalises the team's fixed-pattern Moore detectors into one runtime-configured engine.
- Accepts a pattern/length/overlap configuration over a valid/ready handshake.
- Sequences IDLE/RUN operation with start and stop commands.
- Reports each detection as a registered one-cycle pulse and keeps a saturating match count.
- Sits between the bit-serial receive path and the status/interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16).
CNT_W, 8, width of the match counter.

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cfg_valid  in  1  configuration offer.
cfg_ready  out  1  configuration can be accepted (high only in IDLE).
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received.
cfg_len  in  $clog2(MAX_LEN+1)  pattern length in bits.
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
cfg_err  out  1  one-cycle pulse: handshake completed with illegal cfg_len.
start  in  1  begin detection (IDLE only).
stop  in  1  end detection (RUN only).
in_valid  in  1  serial bit qualifier.
in  in  1  serial data bit.
busy  out  1  high in RUN.
match  out  1  registered one-cycle detection pulse.
match_cnt  out  CNT_W  detections since the last start.
cnt_sat  out  1  sticky: match_cnt reached all-ones.

Behaviour:
- Reset (async, rst=1), all values 0:
  - state=IDLE, cfg_loaded, stored pattern/len/overlap, history, bit count.
  - Outputs match, match_cnt, cnt_sat, cfg_err, busy.
  - cfg_ready=1 once reset is released.
  - Reset mid-RUN aborts immediately; the configuration is lost and must be reloaded.
- States: IDLE, RUN (single bit; defined in the shared package).
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready with 1<=cfg_len<=MAX_LEN: latch pattern, len and overlap; set cfg_loaded.
  - On an illegal cfg_len (0 or >MAX_LEN): keep the old configuration and pulse cfg_err the next cycle.
  - start with cfg_loaded=1 -> RUN next cycle. In the same edge clear history, bit count, match_cnt and cnt_sat.
  - start with cfg_loaded=0 is ignored. stop is ignored.
  - If cfg handshake and start occur in the same cycle, the new config is used for the run.
- RUN:
  - busy=1, cfg_ready=0; cfg_valid is ignored and not consumed.
  - On each in_valid=1 cycle: history <= {history[MAX_LEN-2:0], in}; bit count increments, saturating at len. in_valid=0 leaves everything unchanged.
  - Match condition: the bit count after the shift is >= len AND the new history[len-1:0] equals pattern[len-1:0].
  - On a match, match=1 exactly one cycle, in the cycle following the accepting edge (latency 1). match_cnt increments on that same edge.
  - Overlap mode: the bit count is kept, so a suffix may start the next match.
  - Non-overlap mode: the bit count is cleared to 0 on a match. History still shifts, but a new match needs len fresh bits.
  - stop -> IDLE next cycle. If the bit on the same edge completes a match, that match is still counted and pulsed. start is ignored in RUN; start and stop together means stop.
- Counter:
  - match_cnt saturates at 2^CNT_W-1 with no wrap.
  - cnt_sat is set on the edge the count reaches all-ones and holds until the next start or reset.
- match_cnt and cnt_sat hold their values in IDLE after stop.
- Compare only the low len bits; stored pattern bits at or above len are don't-care.

Decomposition:
- Package seq_det_pkg:
  - State enum {IDLE, RUN}.
  - LEN_W = $clog2(MAX_LEN+1) helper.
  - Default MAX_LEN and CNT_W constants.
- Sub-module seq_shift_matcher holds history, bit count and the masked compare.
  - Inputs: shift enable, clear, overlap, pattern, len.
  - Output: combinational hit.
- The controller holds the FSM, config registers, match register and counter.

Test Plan:
- Pattern 10110, len=5, overlap=0; stream 1,0,1,1,0 -> a single match pulse one cycle after the 5th bit; match_cnt=1.
- Pattern 1011, len=4; stream 1,0,1,1,0,1,1 -> overlap=1 gives match_cnt=2 (after bits 4 and 7); overlap=0 gives match_cnt=1.
- Same 10110 stream with in_valid deasserted for 3 cycles between bits -> identical result, no spurious match during the gaps.
- cfg_len=0 handshake -> cfg_err pulse, cfg_loaded stays 0, start ignored, busy=0. Then cfg_len=3 pattern 111 and start; stream of five 1s in overlap mode -> match_cnt=3.
- CNT_W=2, pattern 1 len=1, six 1s -> match_cnt stops at 3; cnt_sat=1 from the 3rd match; a new start clears both.
- Assert rst mid-RUN after 2 bits of 10110 -> busy, match and match_cnt go 0 immediately and cfg_ready=1 after release. start without a reconfig is ignored; stop and start together in RUN -> IDLE.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state type, default sizes and length-width helper for the pattern detector
package seq_det_pkg;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W = 8;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/seq_shift_matcher.sv
// seq_shift_matcher: bit history, fresh-bit count and masked pattern compare
// clk/rst: clock, async high reset; shift_en: accept bit_in; clr: wipe history and count
// overlap: keep count after a hit; pattern/len: active config; hit: combinational match on this shift
module seq_shift_matcher import seq_det_pkg::*; #(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W = len_w(DEF_MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clr,
  input  logic               bit_in,
  input  logic               overlap,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);
  logic [MAX_LEN-1:0] hist_q, hist_d, mask;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len);
    hist_d = {hist_q[MAX_LEN-2:0], bit_in};
    cnt_inc = cnt_q >= len ? len : cnt_q + LEN_W'(1);
    hit = shift_en && (cnt_inc >= len) && (((hist_d ^ pattern) & mask) == '0);
    // non-overlap restarts the fresh-bit count so the next hit needs len new bits
    cnt_d = clr ? '0 : !shift_en ? cnt_q : (hit && !overlap) ? '0 : cnt_inc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hist_q <= clr ? '0 : shift_en ? hist_d : hist_q;
    end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern detector with IDLE/RUN control and saturating match count
// cfg_valid/cfg_ready/cfg_pattern/cfg_len/cfg_overlap: config handshake (IDLE only); cfg_err: illegal length pulse
// start/stop: run control; in_valid/in: serial bits; busy: in RUN; match: detection pulse
// match_cnt/cnt_sat: saturating count since last start and its sticky full flag
module seq_det_ctrl import seq_det_pkg::*; #(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W = DEF_CNT_W,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic               in,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);
  state_e state_q, state_d;
  logic loaded_q, loaded_d, ov_q, ov_d, match_q, sat_q, sat_d, err_q;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic cfg_fire, cfg_ok, load, go, hit;
  always_comb begin
    cfg_ready = state_q == IDLE;
    busy = state_q == RUN;
    cfg_fire = cfg_valid && cfg_ready;
    cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    load = cfg_fire && cfg_ok;
    loaded_d = loaded_q || load;
    pat_d = load ? cfg_pattern : pat_q;
    len_d = load ? cfg_len : len_q;
    ov_d = load ? cfg_overlap : ov_q;
    // a config accepted on the start edge already counts as loaded
    go = cfg_ready && start && loaded_d;
    state_d = go ? RUN : (busy && stop) ? IDLE : state_q;
    cnt_d = go ? '0 : (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    sat_d = go ? 1'b0 : sat_q || (cnt_d == '1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      loaded_q <= 1'b0;
      pat_q <= '0;
      len_q <= '0;
      ov_q <= 1'b0;
      match_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      loaded_q <= loaded_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ov_q <= ov_d;
      match_q <= hit;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      err_q <= cfg_fire && !cfg_ok;
    end
  seq_shift_matcher #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_match (
    .clk(clk),
    .rst(rst),
    .shift_en(busy && in_valid),
    .clr(go),
    .bit_in(in),
    .overlap(ov_q),
    .pattern(pat_q),
    .len(len_q),
    .hit(hit)
  );
  assign match = match_q;
  assign match_cnt = cnt_q;
  assign cnt_sat = sat_q;
  assign cfg_err = err_q;
endmodule
